pwm_deadtime_gen: RTL
=====================

Name: pwm_deadtime_gen

Overview:
Downstream consumer of the SPWM generator's single-ended pwm_out. Converts one PWM bit into complementary high-side and low-side gate-drive signals for a half-bridge. Guarantees a programmable dead time in which both outputs are low. Adds enable gating and a latched fault shutdown. Runs on the same fast clock as the SPWM generator.

Parameters:
DT_WIDTH, 8, width of the dead_time input and the internal dead-time counter.

Ports:
clk  input  1  system clock, same domain as the SPWM generator
rst_n  input  1  asynchronous active-low reset
pwm_in  input  1  PWM command from the SPWM generator; 1 = high side on
dead_time  input  DT_WIDTH  dead time in clk cycles; 0 is treated as 1
enable  input  1  bridge enable; 0 forces both outputs low
fault_n  input  1  external fault, active low, asynchronous to clk
fault_clear  input  1  one-cycle pulse that releases a latched fault
hs_out  output  1  high-side gate drive
ls_out  output  1  low-side gate drive
fault_latched  output  1  1 while the block is in FAULT
Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: state OFF; hs_out=0, ls_out=0, fault_latched=0; counter=0; pwm_r=0; sync flops=1 (no fault).
- pwm_in is registered once into pwm_r. fault_n passes through a 2-flop synchronizer into flt_s.
- hs_out=(state==HS_ON), ls_out=(state==LS_ON), fault_latched=(state==FAULT). All three are registered state decodes, so they are glitch-free.
- Invariant: hs_out and ls_out are never both 1 in any cycle, including across reset and fault.
- States are OFF, DEAD, HS_ON, LS_ON, FAULT. Transition priority per edge: fault, then enable, then normal operation.
  - Any state except FAULT, with flt_s==0: go to FAULT.
  - Any state except FAULT, with enable==0: go to OFF.
  - OFF, with enable==1: go to DEAD and load cnt = max(dead_time,1). This is the startup dead time.
  - HS_ON, with pwm_r==0: go to DEAD and load cnt = max(dead_time,1).
  - LS_ON, with pwm_r==1: go to DEAD and load cnt = max(dead_time,1).
  - DEAD: cnt decrements each cycle. When cnt==1, go to HS_ON if pwm_r==1, else LS_ON.
  - FAULT: stay while flt_s==0. With fault_clear==1 and flt_s==1, go to OFF.
- dead_time is sampled only at the load. Changing it during DEAD has no effect until the next load.
- pwm_r toggling during DEAD does not restart the count. The target side is chosen from pwm_r at expiry.
- Pulses shorter than the dead time are absorbed. Both outputs stay low for at least D cycles between any side change.
- Latency, with pwm_in edge sampled at clock edge k:
  - Active output drops after edge k+1.
  - Opposite output rises after edge k+1+D, where D = max(dead_time,1).
- Fault latency: fault_n low before edge k forces both outputs low after edge k+2. fault_latched=1 at the same time.
- A fault_clear pulse while flt_s==0 is ignored. The fault is not lost.
- After leaving FAULT or OFF, a full startup dead time always precedes the first on-state.
- Reset asserted mid-operation forces both outputs low immediately, asynchronously.

Decomposition:
- Shared package: state encoding constants (OFF=0, DEAD=1, HS_ON=2, LS_ON=3, FAULT=4, 3-bit state) and the DT_WIDTH default. The SPWM top level reuses these.
- One sub-module: sync_2ff, a generic 2-flop synchronizer with reset value parameter RST_VAL. It is used for fault_n with RST_VAL=1 and is reusable for other asynchronous inputs.

Test Plan:
- Nominal switching: dead_time=4, enable=1, pwm_in square wave of period 40 cycles → ls_out/hs_out alternate; exactly 4 cycles with both low at each transition; hs_out falls 2 edges after the pwm_in fall.
- Short-pulse absorption: dead_time=10, pwm_in high for 3 cycles from an LS_ON steady state → ls_out low for 10 cycles, then ls_out returns high; hs_out stays 0 throughout.
- Zero dead time: dead_time=0 → exactly 1 cycle with both outputs low per transition; hs_out & ls_out never both 1.
- Fault path: fault_n low for 1 cycle during HS_ON → both outputs 0 after 3 edges and fault_latched=1. fault_clear while fault_n low → still FAULT. fault_clear after release → OFF, then 4-cycle DEAD, then the side matching pwm_in.
- Enable and reset: enable dropped during DEAD → OFF next edge. Re-enable → full startup dead time. Async rst_n pulse mid-HS_ON → hs_out=0 immediately; all outputs at reset values.
- Continuous randomized pwm_in with the SPWM generator attached: assertion hs_out&ls_out==0 every cycle, and minimum both-low gap ≥ max(dead_time,1).

Source files
------------

// File: rtl/pwm_deadtime_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_deadtime_gen_pkg
//  Description : Shared state encoding and default widths for the half-bridge
//                dead-time generator and the SPWM top level that uses it.
//  Revision    : 1.0  initial release
// ============================================================================
package pwm_deadtime_gen_pkg;

   // Default width of the dead-time input and the dead-time counter
   localparam int DT_WIDTH_DEFAULT = 8;

   // Bridge state; the encodings are fixed so other blocks can decode them
   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_DEAD  = 3'd1,
      ST_HS_ON = 3'd2,
      ST_LS_ON = 3'd3,
      ST_FAULT = 3'd4
   } pwm_state_e;

endpackage : pwm_deadtime_gen_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Generic two-flop synchronizer for asynchronous inputs, with a
//                selectable value driven while in reset.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_2ff #(
   parameter int   WIDTH   = 1,
   parameter logic RST_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // First flop may go metastable; second flop gives it a cycle to settle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= {WIDTH{RST_VAL}};
         sync_q <= {WIDTH{RST_VAL}};
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/pwm_deadtime_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_deadtime_gen
//  Description : Turns a single-ended PWM command into complementary high-side
//                and low-side gate drives with programmable dead time, enable
//                gating and a latched fault shutdown.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_deadtime_gen
   import pwm_deadtime_gen_pkg::*;
#(
   parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                pwm_in,
   input  logic [DT_WIDTH-1:0] dead_time,
   input  logic                enable,
   input  logic                fault_n,
   input  logic                fault_clear,
   output logic                hs_out,
   output logic                ls_out,
   output logic                fault_latched
);

   pwm_state_e          state_q;
   pwm_state_e          state_d;
   logic [DT_WIDTH-1:0] cnt_q;
   logic [DT_WIDTH-1:0] cnt_d;
   logic [DT_WIDTH-1:0] dt_eff;
   logic                pwm_q;
   logic                flt_s;
   logic                hs_q;
   logic                ls_q;
   logic                flt_q;

   // fault_n is asynchronous to clk; idle (no fault) value while in reset
   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_fault_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (fault_n),
      .sync_o  (flt_s)
   );

   // A programmed dead time of zero still gives one both-low cycle
   assign dt_eff = (dead_time == '0) ? DT_WIDTH'(1) : dead_time;

   // Next-state logic: fault beats enable, enable beats normal switching
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if ((state_q != ST_FAULT) && !flt_s) begin
         state_d = ST_FAULT;
      end else if ((state_q != ST_FAULT) && !enable) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               // enable is known high here: start with a full dead time
               state_d = ST_DEAD;
               cnt_d   = dt_eff;
            end
            ST_HS_ON: begin
               if (!pwm_q) begin
                  state_d = ST_DEAD;
                  cnt_d   = dt_eff;
               end
            end
            ST_LS_ON: begin
               if (pwm_q) begin
                  state_d = ST_DEAD;
                  cnt_d   = dt_eff;
               end
            end
            ST_DEAD: begin
               // The side is picked at expiry, so short pulses are absorbed
               if (cnt_q <= DT_WIDTH'(1)) begin
                  state_d = pwm_q ? ST_HS_ON : ST_LS_ON;
               end else begin
                  cnt_d = cnt_q - DT_WIDTH'(1);
               end
            end
            ST_FAULT: begin
               if (fault_clear && flt_s) begin
                  state_d = ST_OFF;
               end
            end
            default: begin
               state_d = ST_OFF;
            end
         endcase
      end
   end

   // State, counter, input register and glitch-free registered output decodes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         pwm_q   <= 1'b0;
         hs_q    <= 1'b0;
         ls_q    <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pwm_q   <= pwm_in;
         hs_q    <= (state_d == ST_HS_ON);
         ls_q    <= (state_d == ST_LS_ON);
         flt_q   <= (state_d == ST_FAULT);
      end
   end

   assign hs_out        = hs_q;
   assign ls_out        = ls_q;
   assign fault_latched = flt_q;

endmodule : pwm_deadtime_gen
`default_nettype wire
